// File: rtl/conv_job_ctrl.sv
// Host-facing job controller for the convolution core: register file, launch/run FSM,
// memory-ownership handover, cycle accounting and sticky status/interrupt.
module conv_job_ctrl #(
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned HOST_WIDTH    = 32,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  host_wr,
  input  logic                  host_rd,
  input  logic [1:0]            host_addr,
  input  logic [HOST_WIDTH-1:0] host_wdata,
  output logic [HOST_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic [11:0]           core_config,
  output logic                  core_start,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic                  mem_owner_core,
  output logic                  irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_RUN,
    S_FINISH
  } state_t;

  localparam int unsigned MAX_LEN = 2 ** ADDR_WIDTH;
  localparam int unsigned TW      = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  state_t                state;
  logic [11:0]           cfg;
  logic                  irq_en;
  logic                  done_f;
  logic                  cfg_err;
  logic                  overrun;
  logic                  timeout;
  logic [HOST_WIDTH-1:0] cycles;
  logic [TW-1:0]         to_cnt;

  logic                  wr_config;
  logic                  wr_control;
  logic                  wr_status;
  logic                  start_req;
  logic [5:0]            size_x;
  logic [5:0]            size_y;
  logic                  cfg_bad;
  logic [HOST_WIDTH-1:0] rd_mux;
  logic                  unused_wdata;

  assign wr_config  = host_wr && (host_addr == 2'd0);
  assign wr_control = host_wr && (host_addr == 2'd1);
  assign wr_status  = host_wr && (host_addr == 2'd2);
  assign start_req  = wr_control && host_wdata[0];

  assign size_x  = cfg[5:0];
  assign size_y  = cfg[11:6];
  assign cfg_bad = (size_x == '0) || (size_y == '0) ||
                   (32'(size_x) > MAX_LEN) || (32'(size_y) > MAX_LEN);

  assign core_config  = cfg;
  assign irq          = irq_en & (done_f | cfg_err | timeout);
  assign unused_wdata = ^host_wdata[HOST_WIDTH-1:12];

  always_comb begin
    rd_mux = '0;
    case (host_addr)
      2'd0: rd_mux[11:0] = cfg;
      2'd1: rd_mux[1]    = irq_en;
      2'd2: rd_mux[4:0]  = {timeout, overrun, cfg_err, done_f, state != S_IDLE};
      default: rd_mux    = cycles;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      cfg            <= '0;
      irq_en         <= 1'b0;
      done_f         <= 1'b0;
      cfg_err        <= 1'b0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
      cycles         <= '0;
      to_cnt         <= '0;
      core_start     <= 1'b0;
      mem_owner_core <= 1'b0;
      host_rdata     <= '0;
      host_rvalid    <= 1'b0;
    end else begin
      if (wr_config && (state == S_IDLE)) cfg <= host_wdata[11:0];
      if (wr_control) irq_en <= host_wdata[1];
      // W1C comes first so that a same-cycle set from the FSM below wins
      if (wr_status) begin
        if (host_wdata[1]) done_f  <= 1'b0;
        if (host_wdata[2]) cfg_err <= 1'b0;
        if (host_wdata[3]) overrun <= 1'b0;
        if (host_wdata[4]) timeout <= 1'b0;
      end
      if (start_req && (state != S_IDLE)) overrun <= 1'b1;

      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req) state <= S_CHECK;
        end
        S_CHECK: begin
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            mem_owner_core <= 1'b1;
            state          <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // registered pulse lands one cycle after ownership has switched
          core_start <= 1'b1;
          cycles     <= '0;
          to_cnt     <= '0;
          state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (core_busy) begin
            state <= S_RUN;
          end else if (to_cnt == TO_LAST) begin
            timeout        <= 1'b1;
            mem_owner_core <= 1'b0;
            state          <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (cycles != '1) cycles <= cycles + 1'b1;
          if (core_done || !core_busy) state <= S_FINISH;
        end
        S_FINISH: begin
          done_f         <= 1'b1;
          mem_owner_core <= 1'b0;
          state          <= S_IDLE;
        end
        default: begin
          mem_owner_core <= 1'b0;
          state          <= S_IDLE;
        end
      endcase

      host_rvalid <= host_rd;
      if (host_rd) host_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Scoreboard bench for conv_job_ctrl: register reads and signal probes are queued with
// their expected values and compared by a single monitor process.
module tb_conv_job_ctrl;

  logic        clk;
  logic        rstn;
  logic        host_wr;
  logic        host_rd;
  logic [1:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic [11:0] core_config;
  logic        core_start;
  logic        core_busy;
  logic        core_done;
  logic        mem_owner_core;
  logic        irq;

  conv_job_ctrl #(.ADDR_WIDTH(5), .HOST_WIDTH(32), .START_TIMEOUT(8)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .host_wr        (host_wr),
    .host_rd        (host_rd),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata),
    .host_rvalid    (host_rvalid),
    .core_config    (core_config),
    .core_start     (core_start),
    .core_busy      (core_busy),
    .core_done      (core_done),
    .mem_owner_core (mem_owner_core),
    .irq            (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] act;
  } ent_t;

  ent_t rd_q[$];
  ent_t pr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   start_total = 0;
  logic core_mode = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  always @(negedge clk) if (core_start) start_total++;

  // core model: busy one cycle after start, done 20 cycles after busy
  initial begin
    core_busy = 1'b0;
    core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (core_start && (core_mode == 1'b0)) begin
        @(negedge clk);
        core_busy = 1'b1;
        repeat (20) @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_busy = 1'b0;
      end
    end
  end

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (host_rvalid) begin
      if (rd_q.size() == 0) begin
        compare("unexpected_rvalid", host_rdata, 32'hDEAD_BEEF);
      end else begin
        e = rd_q.pop_front();
        compare(e.name, host_rdata, e.exp);
      end
    end
    while (pr_q.size() > 0) begin
      e = pr_q.pop_front();
      compare(e.name, e.act, e.exp);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ent_t e;
    e.name = nm;
    e.exp  = exp;
    e.act  = act;
    pr_q.push_back(e);
  endtask

  task automatic bus(input logic w, input logic r, input logic [1:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input string nm);
    ent_t e;
    host_wr    = w;
    host_rd    = r;
    host_addr  = a;
    host_wdata = d;
    if (r) begin
      e.name = nm;
      e.exp  = exp;
      e.act  = '0;
      rd_q.push_back(e);
    end
    @(negedge clk);
    host_wr = 1'b0;
    host_rd = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d, 32'h0, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, 1'b1, a, 32'h0, exp, nm);
  endtask

  initial begin
    int s0;
    int guard;
    int owner_cyc;
    logic owner_any;

    rstn       = 1'b0;
    host_wr    = 1'b0;
    host_rd    = 1'b0;
    host_addr  = 2'd0;
    host_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_rdata", host_rdata, 32'h0);
    chk("rst_start", 32'(core_start), 32'h0);
    chk("rst_owner", 32'(mem_owner_core), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_config", 32'(core_config), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    rd(2'd2, 32'h0, "rst_status");
    rd(2'd3, 32'h0, "rst_cycles");

    // normal job, 5x3
    wr(2'd0, 32'h0C5);
    s0 = start_total;
    wr(2'd1, 32'h1);
    guard = 0;
    while (!mem_owner_core && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("t1_owner_delay", 32'(guard), 32'd1);
    chk("t1_no_start_with_owner", 32'(core_start), 32'h0);
    owner_cyc = 0;
    while (mem_owner_core && owner_cyc < 200) begin
      owner_cyc++;
      @(negedge clk);
    end
    chk("t1_owner_cycles", 32'(owner_cyc), 32'd24);
    chk("t1_start_pulses", 32'(start_total - s0), 32'd1);
    rd(2'd2, 32'h2, "t1_status_done");
    rd(2'd3, 32'd20, "t1_cycles");
    rd(2'd0, 32'h0C5, "t1_config");
    chk("t1_core_config", 32'(core_config), 32'h0C5);
    chk("t1_irq_disabled", 32'(irq), 32'h0);
    wr(2'd2, 32'h2);
    rd(2'd2, 32'h0, "t1_status_cleared");

    // config error: sizeX = 0, then sizeY = 33
    wr(2'd1, 32'h2);
    wr(2'd0, 32'h0C0);
    s0 = start_total;
    wr(2'd1, 32'h3);
    owner_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_owner_core) owner_any = 1'b1;
      @(negedge clk);
    end
    chk("t2_owner_stays_host", 32'(owner_any), 32'h0);
    chk("t2_no_start", 32'(start_total - s0), 32'h0);
    rd(2'd2, 32'h4, "t2_status_cfgerr");
    chk("t2_irq", 32'(irq), 32'h1);
    rd(2'd1, 32'h2, "t2_control");
    wr(2'd2, 32'h4);
    chk("t2_irq_cleared", 32'(irq), 32'h0);
    wr(2'd0, 32'h841);
    wr(2'd1, 32'h3);
    repeat (3) @(negedge clk);
    rd(2'd2, 32'h4, "t2_sizey33_cfgerr");
    wr(2'd2, 32'h4);

    // start timeout: core never raises busy
    core_mode = 1'b1;
    wr(2'd0, 32'h0C5);
    s0 = start_total;
    wr(2'd1, 32'h3);
    repeat (9) @(negedge clk);
    rd(2'd2, 32'h01, "t3_status_still_waiting");
    rd(2'd2, 32'h10, "t3_status_timeout");
    chk("t3_irq", 32'(irq), 32'h1);
    chk("t3_owner_released", 32'(mem_owner_core), 32'h0);
    chk("t3_start_pulses", 32'(start_total - s0), 32'd1);
    wr(2'd2, 32'h10);
    core_mode = 1'b0;

    // overrun: START and CONFIG writes during RUN, sizeX = 32 is legal
    wr(2'd0, 32'h060);
    s0 = start_total;
    wr(2'd1, 32'h3);
    repeat (9) @(negedge clk);
    wr(2'd1, 32'h3);
    wr(2'd0, 32'h0C5);
    chk("t4_config_held", 32'(core_config), 32'h060);
    rd(2'd2, 32'h9, "t4_status_run_overrun");
    guard = 0;
    while (mem_owner_core && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("t4_job_finished", 32'(guard < 100), 32'h1);
    rd(2'd2, 32'hA, "t4_status_done_overrun");
    rd(2'd3, 32'd20, "t4_cycles");
    rd(2'd0, 32'h060, "t4_config");
    chk("t4_start_pulses", 32'(start_total - s0), 32'd1);
    chk("t4_irq", 32'(irq), 32'h1);
    wr(2'd2, 32'hA);
    chk("t4_irq_cleared", 32'(irq), 32'h0);

    // W1C of DONE on the cycle FINISH sets it (DONE lands 25 cycles after START)
    wr(2'd1, 32'h3);
    repeat (24) @(negedge clk);
    wr(2'd2, 32'h2);
    rd(2'd2, 32'h2, "t5_done_kept");
    chk("t5_irq", 32'(irq), 32'h1);
    bus(1'b1, 1'b1, 2'd2, 32'h2, 32'h2, "t5_wr_rd_old_value");
    rd(2'd2, 32'h0, "t5_done_cleared");
    chk("t5_irq_dropped", 32'(irq), 32'h0);
    rd(2'd3, 32'd20, "t5_cycles");

    // reset in the middle of RUN
    s0 = start_total;
    wr(2'd1, 32'h3);
    repeat (9) @(negedge clk);
    chk("t6_owner_before_reset", 32'(mem_owner_core), 32'h1);
    rstn = 1'b0;
    #1;
    chk("t6_rdata", host_rdata, 32'h0);
    chk("t6_rvalid", 32'(host_rvalid), 32'h0);
    chk("t6_owner", 32'(mem_owner_core), 32'h0);
    chk("t6_start", 32'(core_start), 32'h0);
    chk("t6_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    rd(2'd2, 32'h0, "t6_status_after");
    rd(2'd1, 32'h0, "t6_control_after");
    rd(2'd0, 32'h0, "t6_config_after");
    rd(2'd3, 32'h0, "t6_cycles_after");
    chk("t6_owner_after", 32'(mem_owner_core), 32'h0);
    chk("t6_start_pulses", 32'(start_total - s0), 32'd1);

    repeat (5) @(negedge clk);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
